deparser_src_arbiter: RTL

//  Packet-granular round-robin arbiter that shares one deparser between C_NUM_SRC pipeline lanes.

---
 rtl/deparser_src_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/deparser_src_arbiter.sv
// deparser_src_arbiter
//   Shares one deparser between C_NUM_SRC pipeline lanes. Each lane has its own
//   pkt FIFO and PHV FIFO. One lane at a time is granted, using round-robin
//   order and whole-packet granularity. The granted lane's FIFO heads are muxed
//   to the deparser. The deparser's read strobes are routed back to that lane.
//   The grant is held until the deparser has read the packet's tlast beat and
//   exactly one PHV.
//
// Ports
//   clk, aresetn                 clock, async active-low reset
//   src_pkt_* / src_phv_*        per-lane FIFO heads, empties and read strobes
//   pkt_fifo_* / phv_fifo_*      single FIFO-style interface toward the deparser
//   grant_valid, grant_idx       current grant
//   arb_err                      sticky: deparser read strobe seen while idle
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no lane granted; pick the next eligible lane after last grant
// S_BUSY | lane r_grant_idx owns the deparser until pkt and PHV are done

module deparser_src_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_PKT_VEC_WIDTH    = (6+4+2)*8*8+20*5+256,
  parameter int C_NUM_SRC          = 4,
  parameter int C_SRC_IDX_W        = 2
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic [C_NUM_SRC*C_AXIS_DATA_WIDTH-1:0]      src_pkt_tdata,
  input  logic [C_NUM_SRC*C_AXIS_DATA_WIDTH/8-1:0]    src_pkt_tkeep,
  input  logic [C_NUM_SRC*C_AXIS_TUSER_WIDTH-1:0]     src_pkt_tuser,
  input  logic [C_NUM_SRC-1:0]                        src_pkt_tlast,
  input  logic [C_NUM_SRC-1:0]                        src_pkt_empty,
  output logic [C_NUM_SRC-1:0]                        src_pkt_rd_en,
  input  logic [C_NUM_SRC*C_PKT_VEC_WIDTH-1:0]        src_phv_out,
  input  logic [C_NUM_SRC-1:0]                        src_phv_empty,
  output logic [C_NUM_SRC-1:0]                        src_phv_rd_en,
  output logic [C_AXIS_DATA_WIDTH-1:0]                pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]              pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]               pkt_fifo_tuser,
  output logic                                        pkt_fifo_tlast,
  output logic                                        pkt_fifo_empty,
  input  logic                                        pkt_fifo_rd_en,
  output logic [C_PKT_VEC_WIDTH-1:0]                  phv_fifo_out,
  output logic                                        phv_fifo_empty,
  input  logic                                        phv_fifo_rd_en,
  output logic                                        grant_valid,
  output logic [C_SRC_IDX_W-1:0]                      grant_idx,
  output logic                                        arb_err
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int PW = C_PKT_VEC_WIDTH;
  localparam int IW = C_SRC_IDX_W;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   r_grant_idx;
  logic            r_pkt_done;
  logic            r_phv_done;
  logic            r_arb_err;

  logic [C_NUM_SRC-1:0] w_elig;
  logic                 w_busy;
  logic                 w_found;
  logic [IW-1:0]        w_next;
  logic [IW-1:0]        w_cand;

  logic [DW-1:0]   w_g_tdata;
  logic [KW-1:0]   w_g_tkeep;
  logic [UW-1:0]   w_g_tuser;
  logic            w_g_tlast;
  logic            w_g_pkt_empty;
  logic [PW-1:0]   w_g_phv;
  logic            w_g_phv_empty;

  logic            w_pkt_rd;
  logic            w_phv_rd;
  logic            w_pkt_fin;
  logic            w_phv_fin;

  assign w_elig = ~src_pkt_empty & ~src_phv_empty;
  assign w_busy = (r_state == S_BUSY);

  // Round-robin search starting one past the last granted lane, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    w_cand  = '0;
    for (int k = 1; k <= C_NUM_SRC; k++) begin
      w_cand = IW'((int'(r_last_grant) + k) % C_NUM_SRC);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_next  = w_cand;
      end
    end
  end

  // Select the granted lane's FIFO heads. Constant-index slices keep the mux simple.
  always_comb begin
    w_g_tdata     = '0;
    w_g_tkeep     = '0;
    w_g_tuser     = '0;
    w_g_tlast     = 1'b0;
    w_g_pkt_empty = 1'b1;
    w_g_phv       = '0;
    w_g_phv_empty = 1'b1;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (r_grant_idx == IW'(i)) begin
        w_g_tdata     = src_pkt_tdata[i*DW +: DW];
        w_g_tkeep     = src_pkt_tkeep[i*KW +: KW];
        w_g_tuser     = src_pkt_tuser[i*UW +: UW];
        w_g_tlast     = src_pkt_tlast[i];
        w_g_pkt_empty = src_pkt_empty[i];
        w_g_phv       = src_phv_out[i*PW +: PW];
        w_g_phv_empty = src_phv_empty[i];
      end
    end
  end

  // Reads after a done flag are masked. This protects the lane's next packet and PHV.
  assign w_pkt_rd  = w_busy & pkt_fifo_rd_en & ~r_pkt_done;
  assign w_phv_rd  = w_busy & phv_fifo_rd_en & ~r_phv_done;
  assign w_pkt_fin = r_pkt_done | (w_pkt_rd & w_g_tlast);
  assign w_phv_fin = r_phv_done | w_phv_rd;

  always_comb begin
    src_pkt_rd_en = '0;
    src_phv_rd_en = '0;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (r_grant_idx == IW'(i)) begin
        src_pkt_rd_en[i] = w_pkt_rd;
        src_phv_rd_en[i] = w_phv_rd;
      end
    end
  end

  assign pkt_fifo_tdata = w_busy ? w_g_tdata : '0;
  assign pkt_fifo_tkeep = w_busy ? w_g_tkeep : '0;
  assign pkt_fifo_tuser = w_busy ? w_g_tuser : '0;
  assign pkt_fifo_tlast = w_busy & w_g_tlast;
  assign pkt_fifo_empty = w_busy ? (w_g_pkt_empty | r_pkt_done) : 1'b1;
  assign phv_fifo_out   = w_busy ? w_g_phv : '0;
  assign phv_fifo_empty = w_busy ? (w_g_phv_empty | r_phv_done) : 1'b1;
  assign grant_valid    = w_busy;
  assign grant_idx      = w_busy ? r_grant_idx : '0;
  assign arb_err        = r_arb_err;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= IW'(C_NUM_SRC - 1);
      r_grant_idx  <= '0;
      r_pkt_done   <= 1'b0;
      r_phv_done   <= 1'b0;
      r_arb_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pkt_done <= 1'b0;
          r_phv_done <= 1'b0;
          if (pkt_fifo_rd_en || phv_fifo_rd_en) r_arb_err <= 1'b1;
          if (w_found) begin
            r_state     <= S_BUSY;
            r_grant_idx <= w_next;
          end
        end
        S_BUSY: begin
          // Release on the cycle both halves complete, including the same-cycle case.
          if (w_pkt_fin && w_phv_fin) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_grant_idx;
            r_pkt_done   <= 1'b0;
            r_phv_done   <= 1'b0;
          end else begin
            r_pkt_done <= w_pkt_fin;
            r_phv_done <= w_phv_fin;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
